// File: rtl/master_output_drain_ctrl_if.sv
// Drain-job request/status bundle and output-buffer write lanes of the accumulator drain controller.
// The master side issues jobs and holds reads. The slave side is the drain controller.
interface master_output_drain_ctrl_if #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
);
  localparam int RW = $clog2(SYS_ARR_ROWS);
  localparam int CW = $clog2(SYS_ARR_COLS);
  localparam int MW = (MAX_OUT_ROWS / SYS_ARR_ROWS > 1) ? $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS) : 1;
  localparam int NW = (MAX_OUT_COLS / SYS_ARR_COLS > 1) ? $clog2(MAX_OUT_COLS / SYS_ARR_COLS) : 1;

  logic                               start;
  logic [MW-1:0]                      submat_row_in;
  logic [NW-1:0]                      submat_col_in;
  logic [RW-1:0]                      num_rows_read;
  logic [CW-1:0]                      num_cols_read;
  logic [ADDR_WIDTH-1:0]              wr_base_addr;
  logic                               activate;
  logic                               clear_after;
  logic                               hold;
  logic                               busy;
  logic                               done;
  logic [MW-1:0]                      submat_row_out;
  logic [NW-1:0]                      submat_col_out;
  logic [RW-1:0]                      row_num;
  logic                               rd_en;
  logic                               relu_en;
  logic                               accum_reset;
  logic [SYS_ARR_COLS-1:0]            wr_en;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr;

  modport master (
    output start, submat_row_in, submat_col_in, num_rows_read, num_cols_read,
           wr_base_addr, activate, clear_after, hold,
    input  busy, done, submat_row_out, submat_col_out, row_num, rd_en,
           relu_en, accum_reset, wr_en, wr_addr
  );

  modport slave (
    input  start, submat_row_in, submat_col_in, num_rows_read, num_cols_read,
           wr_base_addr, activate, clear_after, hold,
    output busy, done, submat_row_out, submat_col_out, row_num, rd_en,
           relu_en, accum_reset, wr_en, wr_addr
  );
endinterface

// File: rtl/master_output_drain_ctrl.sv
// Drains one accumulator submatrix per job: row reads, then masked writes RD_LATENCY cycles later.
// Done arrives at start+1+rows+RD_LATENCY (+1 with clear). hold pauses read issue only; the write pipeline keeps draining.
module master_output_drain_ctrl #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 2,
  parameter int ROW_STRIDE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  master_output_drain_ctrl_if.slave     bus
);
  localparam int RW = $clog2(SYS_ARR_ROWS);
  localparam int CW = $clog2(SYS_ARR_COLS);
  localparam int MW = (MAX_OUT_ROWS / SYS_ARR_ROWS > 1) ? $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS) : 1;
  localparam int NW = (MAX_OUT_COLS / SYS_ARR_COLS > 1) ? $clog2(MAX_OUT_COLS / SYS_ARR_COLS) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, CLEAR, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [RW-1:0]         rows_q;
  logic [CW-1:0]         cols_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  act_q;
  logic                  clr_q;
  logic [MW-1:0]         srow_q;
  logic [NW-1:0]         scol_q;
  logic [RW-1:0]         cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RW-1:0]         pipe_row [RD_LATENCY];
  logic                  accept;
  logic                  issue;
  logic                  last_issue;
  logic                  flush_done;
  logic                  out_vld;
  logic [ADDR_WIDTH-1:0] lane_addr;

  assign accept     = (state == IDLE) && bus.start;
  assign issue      = (state == ISSUE) && !bus.hold;
  assign last_issue = issue && (cnt == rows_q);

  // The last stage drains this cycle, so only the earlier stages must be empty to leave FLUSH.
  always_comb begin
    flush_done = 1'b1;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      if (pipe_vld[i]) flush_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = ISSUE;
      ISSUE:   if (last_issue) next_state = FLUSH;
      FLUSH:   if (flush_done) next_state = clr_q ? CLEAR : DONE;
      CLEAR:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q <= '0;
      cols_q <= '0;
      base_q <= '0;
      act_q  <= 1'b0;
      clr_q  <= 1'b0;
      srow_q <= '0;
      scol_q <= '0;
    end else if (accept) begin
      rows_q <= bus.num_rows_read;
      cols_q <= bus.num_cols_read;
      base_q <= bus.wr_base_addr;
      act_q  <= bus.activate;
      clr_q  <= bus.clear_after;
      srow_q <= bus.submat_row_in;
      scol_q <= bus.submat_col_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                     cnt <= '0;
    else if (accept || last_issue) cnt <= '0;
    else if (issue)                cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Row tags need no reset: they are only observed qualified by pipe_vld.
  always_ff @(posedge clk) begin
    pipe_row[0] <= cnt;
    for (int i = 1; i < RD_LATENCY; i++) pipe_row[i] <= pipe_row[i-1];
  end

  always_comb begin
    out_vld            = pipe_vld[RD_LATENCY-1];
    lane_addr          = base_q + ADDR_WIDTH'(ADDR_WIDTH'(pipe_row[RD_LATENCY-1]) * ADDR_WIDTH'(ROW_STRIDE));
    bus.busy           = (state != IDLE);
    bus.done           = (state == DONE);
    bus.accum_reset    = (state == CLEAR);
    bus.rd_en          = issue;
    bus.row_num        = cnt;
    bus.relu_en        = out_vld && act_q;
    bus.submat_row_out = srow_q;
    bus.submat_col_out = scol_q;
    bus.wr_en          = '0;
    bus.wr_addr        = '0;
    for (int i = 0; i < SYS_ARR_COLS; i++) begin
      bus.wr_en[i]                          = out_vld && (CW'(i) <= cols_q);
      bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = out_vld ? lane_addr : '0;
    end
  end
endmodule

// File: tb/tb_master_output_drain_ctrl.sv
// Drives identical random drain jobs into two controllers (row stride 1 and 16) and scoreboards reads, writes, clear and done.
module tb_master_output_drain_ctrl;
  localparam int RDL = 2;

  typedef struct { int cyc; int row; } rd_ev_t;
  typedef struct { int cyc; logic [15:0] en; logic [7:0] addr; bit relu; } wr_ev_t;
  typedef struct { int cyc; int srow; int scol; } dn_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] srow = '0;
  logic [2:0] scol = '0;
  logic [3:0] nrows = '0;
  logic [3:0] ncols = '0;
  logic [7:0] base_v = '0;
  logic act_v = 1'b0;
  logic clr_v = 1'b0;
  logic hold = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_lo = 1;
  int busy_hi = 0;

  rd_ev_t rdq[$];
  wr_ev_t wrq_a[$];
  wr_ev_t wrq_b[$];
  dn_ev_t dnq[$];
  int     accq[$];

  master_output_drain_ctrl_if ia ();
  master_output_drain_ctrl_if ib ();

  assign ia.start = start;        assign ib.start = start;
  assign ia.submat_row_in = srow; assign ib.submat_row_in = srow;
  assign ia.submat_col_in = scol; assign ib.submat_col_in = scol;
  assign ia.num_rows_read = nrows; assign ib.num_rows_read = nrows;
  assign ia.num_cols_read = ncols; assign ib.num_cols_read = ncols;
  assign ia.wr_base_addr = base_v; assign ib.wr_base_addr = base_v;
  assign ia.activate = act_v;     assign ib.activate = act_v;
  assign ia.clear_after = clr_v;  assign ib.clear_after = clr_v;
  assign ia.hold = hold;          assign ib.hold = hold;

  master_output_drain_ctrl #(.RD_LATENCY(RDL), .ROW_STRIDE(1))  dut_a (.clk(clk), .reset(reset), .bus(ia));
  master_output_drain_ctrl #(.RD_LATENCY(RDL), .ROW_STRIDE(16)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble();
    srow   = 3'($urandom);
    scol   = 3'($urandom);
    nrows  = 4'($urandom);
    ncols  = 4'($urandom);
    base_v = 8'($urandom);
    act_v  = 1'($urandom);
    clr_v  = 1'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {ib.busy, ia.busy}, 0);
    check({tag, "_done"}, {ib.done, ia.done}, 0);
    check({tag, "_accum_reset"}, {ib.accum_reset, ia.accum_reset}, 0);
    check({tag, "_rd_en"}, {ib.rd_en, ia.rd_en}, 0);
    check({tag, "_wr_en"}, {ib.wr_en, ia.wr_en}, 0);
    check({tag, "_wr_addr"}, ia.wr_addr | ib.wr_addr, 0);
    check({tag, "_relu"}, {ib.relu_en, ia.relu_en}, 0);
    check({tag, "_submat"}, {ib.submat_row_out, ib.submat_col_out, ia.submat_row_out, ia.submat_col_out}, 0);
  endtask

  // Model: row k is read on the k-th hold-free ISSUE cycle and written RDL cycles later.
  task automatic run_job(input int rows, input int cols, input int base, input bit act, input bit clr,
                         input int hmode, input int hafter, input int hlen,
                         input bit mid, input bit dstart, input bit abort);
    int t, p, issued, last, dcyc, hcnt, sr, sc, mask;
    bit h;
    rd_ev_t r;
    wr_ev_t w;
    dn_ev_t d;
    tick();
    t = cyc;
    sr = $urandom_range(0, 7);
    sc = $urandom_range(0, 7);
    start = 1'b1; srow = 3'(sr); scol = 3'(sc);
    nrows = 4'(rows); ncols = 4'(cols); base_v = 8'(base); act_v = act; clr_v = clr;
    hold = 1'($urandom);
    busy_lo = t + 1;
    busy_hi = 32'h7fff_ffff;
    mask = (1 << (cols + 1)) - 1;
    issued = 0; hcnt = 0; p = t;
    while (issued < rows + 1) begin
      tick();
      p = cyc;
      scramble();
      start = mid && (p == t + 2);
      h = 1'b0;
      if (hmode == 1 && issued == hafter && hcnt < hlen) begin
        h = 1'b1;
        hcnt++;
      end else if (hmode == 2) begin
        h = ($urandom_range(0, 3) == 0);
      end
      hold = h;
      if (!h) begin
        r.cyc = p; r.row = issued;
        rdq.push_back(r);
        w.cyc = p + RDL; w.en = mask[15:0]; w.relu = act;
        w.addr = 8'((base + issued) % 256);
        wrq_a.push_back(w);
        w.addr = 8'((base + issued * 16) % 256);
        wrq_b.push_back(w);
        issued++;
      end
    end
    last = p;
    dcyc = last + RDL + 1 + int'(clr);
    busy_hi = dcyc;
    if (clr) accq.push_back(last + RDL + 1);
    d.cyc = dcyc; d.srow = sr; d.scol = sc;
    dnq.push_back(d);
    if (abort) begin
      tick();
      start = 1'b0; hold = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      busy_hi = last + 1;
      while (wrq_a.size() > 0 && wrq_a[$].cyc >= cyc) void'(wrq_a.pop_back());
      while (wrq_b.size() > 0 && wrq_b[$].cyc >= cyc) void'(wrq_b.pop_back());
      while (accq.size() > 0 && accq[$] >= cyc) void'(accq.pop_back());
      while (dnq.size() > 0 && dnq[$].cyc >= cyc) void'(dnq.pop_back());
      #1;
      check_idle_outputs("abort");
      return;
    end
    while (cyc < dcyc) begin
      tick();
      scramble();
      start = 1'b0;
      hold = 1'($urandom);
    end
    start = dstart;
  endtask

  always @(negedge clk) begin : monitor
    bit e;
    rd_ev_t r;
    wr_ev_t w;
    dn_ev_t d;
    if (cyc >= 1) begin
      check("busy_a", ia.busy, (cyc >= busy_lo && cyc <= busy_hi));
      check("busy_b", ib.busy, (cyc >= busy_lo && cyc <= busy_hi));

      e = rdq.size() > 0 && rdq[0].cyc == cyc;
      if (e || ia.rd_en || ib.rd_en) begin
        check("rd_en", {ib.rd_en, ia.rd_en}, {e, e});
        if (e) begin
          r = rdq.pop_front();
          check("row_num_a", ia.row_num, r.row);
          check("row_num_b", ib.row_num, r.row);
        end
      end

      e = wrq_a.size() > 0 && wrq_a[0].cyc == cyc;
      if (e || (|ia.wr_en) || ia.relu_en) begin
        if (e) begin
          w = wrq_a.pop_front();
          check("wr_en_a", ia.wr_en, w.en);
          check("wr_addr_a", ia.wr_addr, {16{w.addr}});
          check("relu_en_a", ia.relu_en, w.relu);
        end else begin
          check("wr_unexpected_a", {ia.relu_en, ia.wr_en}, 0);
        end
      end

      e = wrq_b.size() > 0 && wrq_b[0].cyc == cyc;
      if (e || (|ib.wr_en) || ib.relu_en) begin
        if (e) begin
          w = wrq_b.pop_front();
          check("wr_en_b", ib.wr_en, w.en);
          check("wr_addr_b", ib.wr_addr, {16{w.addr}});
          check("relu_en_b", ib.relu_en, w.relu);
        end else begin
          check("wr_unexpected_b", {ib.relu_en, ib.wr_en}, 0);
        end
      end

      e = accq.size() > 0 && accq[0] == cyc;
      if (e || ia.accum_reset || ib.accum_reset) begin
        check("accum_reset", {ib.accum_reset, ia.accum_reset}, {e, e});
        if (e) void'(accq.pop_front());
      end

      e = dnq.size() > 0 && dnq[0].cyc == cyc;
      if (e || ia.done || ib.done) begin
        check("done", {ib.done, ia.done}, {e, e});
        if (e) begin
          d = dnq.pop_front();
          check("submat_row_out", {ib.submat_row_out, ia.submat_row_out}, {3'(d.srow), 3'(d.srow)});
          check("submat_col_out", {ib.submat_col_out, ia.submat_col_out}, {3'(d.scol), 3'(d.scol)});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_idle_outputs("reset");

    // rows, cols, base, act, clr, hmode, hafter, hlen, mid, dstart, abort
    run_job(15, 15, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    run_job(3, 4, 8'h40, 1, 1, 0, 0, 0, 0, 1, 0);
    run_job(2, 7, 8'hF0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_job(5, 9, 8'h22, 1, 0, 1, 2, 3, 0, 0, 0);
    run_job(6, 3, 8'h80, 1, 1, 0, 0, 0, 0, 0, 1);
    run_job(0, 0, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 24; j++) begin
      run_job($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
              1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 0,
              1'($urandom), 1'($urandom), 1'b0);
    end

    tick();
    start = 1'b0;
    repeat (6) tick();
    check("queues_drained", rdq.size() + wrq_a.size() + wrq_b.size() + dnq.size() + accq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
